i2c_reg_bank: RTL and testbench
===============================

Name: i2c_reg_bank

Overview:
Parametrised I2C register bank that sits behind the byte-level I2C slave core. It holds N_RW read/write control registers and N_RO read-only status registers, each REG_W bits wide, behind an 8-bit auto-incrementing byte pointer. Multi-byte writes commit atomically, multi-byte status reads are snapshot-coherent, and one register is a self-clearing pulse register. Everything is clocked on clk; no logic is clocked by protocol strobes.

Parameters:
N_RW, 8, number of read/write registers
N_RO, 4, number of read-only status registers
REG_W, 32, register width in bits; multiple of 8, 8..32; BPR = REG_W/8 bytes per register
RO_BASE, 8'h40, byte address of RO register 0
PULSE_IDX, 7, index of the self-clearing RW register
PULSE_CYCLES, 3, clk cycles a nonzero pulse-register value persists
RST_VALS, 0, packed N_RW*REG_W reset values; register k uses bits [k*REG_W +: REG_W]

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse after slave-address match (start or repeated start); r_w valid this cycle
stop  in  1  one-cycle pulse on I2C stop
data_vld  in  1  one-cycle pulse: write = rx_data received; read = tx_data byte consumed (acked)
r_w  in  1  0 = master write, 1 = master read; stable from start until stop or next start
rx_data  in  8  received byte
tx_data  out  8  byte at the current pointer, registered
rw_regs  out  N_RW*REG_W  committed RW register values
ro_regs  in  N_RO*REG_W  live status inputs
commit  out  N_RW  one-cycle strobe per register on atomic commit
addr_err  out  1  one-cycle strobe on a write to an unmapped or RO byte

Behaviour:
- Reset: rw_regs = RST_VALS; tx_data = 0; commit = 0; addr_err = 0; pointer = 0; staging = 0; snapshot = 0; pulse counter = 0; FSM = IDLE.
- Map: RW reg k byte b at k*BPR+b. RO reg k byte b at RO_BASE+k*BPR+b. Everything else is unmapped: reads 8'h00, writes ignored and strobe addr_err.
- FSM states: IDLE, PTR, WR, RD.
- Transitions: start with r_w=0 goes to PTR. start with r_w=1 goes to RD. stop from any state goes to IDLE. start in any state re-enters per r_w.
- PTR: first data_vld loads pointer = rx_data, then WR.
- WR: each data_vld writes rx_data into the staging byte for the pointer, then pointer increments. A write to byte BPR-1 of RW reg k copies staging into reg k in the same cycle and pulses commit[k] on the next cycle. Partial staging is discarded on stop or start.
- RD: each data_vld increments the pointer.
- Pointer: 8-bit, wraps 8'hFF to 8'h00. It persists across transactions, so write-pointer then repeated-start read works.
- tx_data: registered from the pointer and reflects the new pointer 1 clk after any pointer change. The slave core guarantees at least 2 clk between data_vld and its next byte load.
- RW reads return committed values, never staging.
- RO snapshot: when the pointer lands on byte 0 of an RO register (load or increment), the whole register is captured. Bytes 1..BPR-1 of that register read from the snapshot.
- Pulse register: a commit of a nonzero value loads the counter with PULSE_CYCLES. The register clears to 0 when the counter expires. A re-commit during countdown reloads the counter. Committing 0 cancels the countdown.
- Simultaneous events:
  - stop with data_vld: stop wins, byte discarded.
  - start with data_vld: start wins.
  - Pulse clear in the same cycle as a commit to PULSE_IDX: the commit wins.
- rst mid-transaction restores the full reset state immediately.

Decomposition:
- Package i2c_regs_pkg holds:
  - the FSM state encoding;
  - the BPR calculation;
  - the address-decode helper functions (is_rw, is_ro, reg_index, byte_index).
- One sub-module, i2c_reg_pulse_timer: the countdown and clear logic for the pulse register.

Test Plan:
(defaults: BPR=4)
- Reset: assert rst mid-write. rw_regs = RST_VALS, tx_data = 00, commit = 0, and the next read at pointer 0 returns byte 0 of RST_VALS.
- Atomic write: pointer 0x04, then bytes 11 22 33 44. reg1 is unchanged after byte 3 and becomes 0x44332211 after byte 4. commit[1] is high for exactly one cycle.
- Aborted write: pointer 0x08, then AA BB, then stop. reg2 is unchanged and commit stays 0.
- Coherent RO read: pointer 0x40, repeated-start read of 4 bytes. ro_regs[31:0] changes from 0x12345678 to 0x9ABCDEF0 after byte 1. Bytes read are 78 56 34 12.
- Pulse: write 0x1C, then 01 00 00 00. reg7 = 1 for 3 clk after commit, then 0. A rewrite at cycle 2 extends it to 3 clk after the rewrite.
- Wrap and unmapped access:
  - Write pointer 0xFE, then read 3 bytes. Reads return 00 00, then byte 0 of reg0.
  - Write pointer 0x30 followed by a data byte. addr_err pulses once and no register changes.

Source files
------------

// File: rtl/i2c_regs_pkg.sv
// Shared types and address-decode helpers for the I2C register bank.
// Addresses are byte pointers; register/byte indices are plain ints.
package i2c_regs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PTR  = 2'd1,
    ST_WR   = 2'd2,
    ST_RD   = 2'd3
  } state_t;

  function automatic int calc_bpr(input int reg_w);
    return reg_w / 8;
  endfunction

  function automatic logic is_rw(input logic [7:0] addr, input int n_rw, input int bpr);
    return int'(addr) < n_rw * bpr;
  endfunction

  function automatic logic is_ro(input logic [7:0] addr, input int base, input int n_ro,
                                 input int bpr);
    return (int'(addr) >= base) && (int'(addr) < base + n_ro * bpr);
  endfunction

  function automatic int reg_index(input logic [7:0] addr, input int base, input int bpr);
    return (int'(addr) - base) / bpr;
  endfunction

  function automatic int byte_index(input logic [7:0] addr, input int base, input int bpr);
    return (int'(addr) - base) % bpr;
  endfunction

endpackage

// File: rtl/i2c_reg_pulse_timer.sv
// Down-counter that clears the self-clearing pulse register after a fixed
// number of cycles; a fresh commit always overrides the terminal count.
module i2c_reg_pulse_timer #(
  parameter int PULSE_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic load_nz,
  output logic clr
);

  localparam int CW = $clog2(PULSE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(PULSE_CYCLES);

  logic [CW-1:0] cnt;

  assign clr = !load && (cnt == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_nz ? CNT_INIT : '0;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/i2c_reg_bank.sv
// Register bank behind a byte-level I2C slave: auto-increment pointer,
// atomic multi-byte RW commits, snapshot-coherent RO reads, one pulse register.
//
//   state   | meaning
//   IDLE    | no transaction addressed to us
//   PTR     | write transaction, next byte loads the pointer
//   WR      | write transaction, bytes go to staging at the pointer
//   RD      | read transaction, each consumed byte advances the pointer
module i2c_reg_bank
  import i2c_regs_pkg::*;
#(
  parameter int                     N_RW         = 8,
  parameter int                     N_RO         = 4,
  parameter int                     REG_W        = 32,
  parameter logic [7:0]             RO_BASE      = 8'h40,
  parameter int                     PULSE_IDX    = 7,
  parameter int                     PULSE_CYCLES = 3,
  parameter logic [N_RW*REG_W-1:0]  RST_VALS     = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    data_vld,
  input  logic                    r_w,
  input  logic [7:0]              rx_data,
  output logic [7:0]              tx_data,
  output logic [N_RW*REG_W-1:0]   rw_regs,
  input  logic [N_RO*REG_W-1:0]   ro_regs,
  output logic [N_RW-1:0]         commit,
  output logic                    addr_err
);

  localparam int BPR       = calc_bpr(REG_W);
  localparam int RO_BASE_I = int'(RO_BASE);
  // Byte 0 of an RO register is always read live, so only the upper bytes are held.
  localparam int SNAP_W    = (BPR > 1) ? REG_W - 8 : 8;

  state_t             state, state_nxt;
  logic [7:0]         ptr, ptr_nxt;
  logic               ptr_chg;
  logic [REG_W-1:0]   stage, stage_nxt;
  logic [SNAP_W-1:0]  snap;
  logic [N_RW-1:0]    commit_hit;
  logic               addr_err_nxt;
  logic [7:0]         rd_byte;
  logic               pulse_clr;
  logic               ro_land;
  int                 wr_ri, wr_bi, land_ri;

  assign wr_ri   = reg_index(ptr, 0, BPR);
  assign wr_bi   = byte_index(ptr, 0, BPR);
  assign land_ri = reg_index(ptr_nxt, RO_BASE_I, BPR);
  assign ro_land = ptr_chg && is_ro(ptr_nxt, RO_BASE_I, N_RO, BPR)
                   && (byte_index(ptr_nxt, RO_BASE_I, BPR) == 0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // stop outranks start, and both outrank a coincident data byte.
  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    ptr_chg      = 1'b0;
    stage_nxt    = stage;
    commit_hit   = '0;
    addr_err_nxt = 1'b0;
    if (stop) begin
      state_nxt = ST_IDLE;
      stage_nxt = '0;
    end else if (start) begin
      state_nxt = r_w ? ST_RD : ST_PTR;
      stage_nxt = '0;
    end else if (data_vld) begin
      case (state)
        ST_PTR: begin
          ptr_nxt   = rx_data;
          ptr_chg   = 1'b1;
          state_nxt = ST_WR;
        end
        ST_WR: begin
          ptr_nxt = ptr + 8'd1;
          ptr_chg = 1'b1;
          if (is_rw(ptr, N_RW, BPR)) begin
            for (int b = 0; b < BPR; b++)
              if (wr_bi == b) stage_nxt[b*8 +: 8] = rx_data;
            if (wr_bi == BPR - 1)
              for (int k = 0; k < N_RW; k++)
                if (wr_ri == k) commit_hit[k] = 1'b1;
          end else begin
            addr_err_nxt = 1'b1;
          end
        end
        ST_RD: begin
          ptr_nxt = ptr + 8'd1;
          ptr_chg = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_byte = '0;
    for (int a = 0; a < N_RW * BPR; a++)
      if (int'(ptr) == a) rd_byte = rw_regs[a*8 +: 8];
    for (int o = 0; o < N_RO * BPR; o++)
      if (int'(ptr) == RO_BASE_I + o) begin
        if (o % BPR == 0) rd_byte = ro_regs[o*8 +: 8];
        else              rd_byte = snap[((o % BPR) - 1)*8 +: 8];
      end
  end

  i2c_reg_pulse_timer #(
    .PULSE_CYCLES (PULSE_CYCLES)
  ) u_pulse_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (commit_hit[PULSE_IDX]),
    .load_nz (|stage_nxt),
    .clr     (pulse_clr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      stage    <= '0;
      snap     <= '0;
      tx_data  <= '0;
      commit   <= '0;
      addr_err <= 1'b0;
      rw_regs  <= RST_VALS;
    end else begin
      ptr      <= ptr_nxt;
      stage    <= stage_nxt;
      tx_data  <= rd_byte;
      commit   <= commit_hit;
      addr_err <= addr_err_nxt;
      if (ro_land)
        for (int k = 0; k < N_RO; k++)
          if (land_ri == k) snap <= SNAP_W'(ro_regs[k*REG_W +: REG_W] >> 8);
      for (int k = 0; k < N_RW; k++) begin
        if (commit_hit[k])                   rw_regs[k*REG_W +: REG_W] <= stage_nxt;
        else if (k == PULSE_IDX && pulse_clr) rw_regs[k*REG_W +: REG_W] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Scoreboard bench for i2c_reg_bank: tests push expected read bytes,
// a negedge monitor pops and compares them as the master consumes bytes.
module tb_i2c_reg_bank;

  localparam int N_RW = 8;
  localparam int N_RO = 4;
  localparam int REG_W = 32;
  localparam logic [31:0] R0 = 32'hDEAD_BEEF;
  localparam logic [31:0] R1 = 32'h0102_0304;
  localparam logic [31:0] R2 = 32'hCAFE_F00D;
  localparam logic [N_RW*REG_W-1:0] RST_VALS = {{5{32'h0}}, R2, R1, R0};

  logic                  clk, rst, start, stop, data_vld, r_w;
  logic [7:0]            rx_data, tx_data;
  logic [N_RW*REG_W-1:0] rw_regs;
  logic [N_RO*REG_W-1:0] ro_regs;
  logic [N_RW-1:0]       commit;
  logic                  addr_err;

  int total = 0;
  int bad = 0;
  int commit_seen = 0;
  int aerr_seen = 0;
  logic [7:0] exp_q[$];

  i2c_reg_bank #(
    .N_RW(N_RW), .N_RO(N_RO), .REG_W(REG_W), .RO_BASE(8'h40),
    .PULSE_IDX(7), .PULSE_CYCLES(3), .RST_VALS(RST_VALS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .data_vld(data_vld),
    .r_w(r_w), .rx_data(rx_data), .tx_data(tx_data), .rw_regs(rw_regs),
    .ro_regs(ro_regs), .commit(commit), .addr_err(addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && commit != '0) commit_seen++;
    if (!rst && addr_err) aerr_seen++;
    if (!rst && data_vld && r_w && !start && !stop) begin
      logic [7:0] e;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rd_unexpected: tx_data=%02h with no byte expected", tx_data);
      end else begin
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          bad++;
          $display("FAIL rd_byte: tx_data=%02h expected=%02h", tx_data, e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask
  task automatic gap();
    cyc(); cyc();
  endtask
  task automatic send_start(input logic rw);
    r_w = rw; start = 1'b1; cyc(); start = 1'b0; gap();
  endtask
  task automatic send_stop();
    stop = 1'b1; cyc(); stop = 1'b0; gap();
  endtask
  task automatic send_byte(input logic [7:0] b);
    rx_data = b; data_vld = 1'b1; cyc(); data_vld = 1'b0; gap();
  endtask

  task automatic test_reset();
    total++;
    if (rw_regs !== RST_VALS) begin bad++; $display("FAIL reset_rw: got %h expected %h", rw_regs, RST_VALS); end
    total++;
    if (tx_data !== 8'h00 || commit !== '0 || addr_err !== 1'b0) begin
      bad++; $display("FAIL reset_out: tx=%02h commit=%02h aerr=%b expected 00/00/0", tx_data, commit, addr_err);
    end
    rst = 1'b0; gap();
    send_start(1'b0); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    total++;
    if (rw_regs[31:0] !== 32'h0403_0201) begin bad++; $display("FAIL pre_reset_write: reg0=%h expected 04030201", rw_regs[31:0]); end
    send_start(1'b0); send_byte(8'h04); send_byte(8'h99);
    rst = 1'b1; #1;
    total++;
    if (rw_regs !== RST_VALS || tx_data !== 8'h00 || commit !== '0) begin
      bad++; $display("FAIL mid_reset: rw=%h tx=%02h commit=%02h expected RST_VALS/00/00", rw_regs, tx_data, commit);
    end
    cyc(); rst = 1'b0; cyc();
    send_start(1'b1);
    exp_q.push_back(R0[7:0]);
    send_byte(8'h00);
    send_stop();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL reset_read_left: %0d bytes not read, expected 0", exp_q.size()); end
  endtask

  task automatic test_atomic_write();
    send_start(1'b0); send_byte(8'h04);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    total++;
    if (rw_regs[63:32] !== R1 || commit !== '0) begin
      bad++; $display("FAIL partial_write: reg1=%h commit=%02h expected %h/00", rw_regs[63:32], commit, R1);
    end
    rx_data = 8'h44; data_vld = 1'b1; cyc(); data_vld = 1'b0;
    total++;
    if (commit !== 8'h02 || rw_regs[63:32] !== 32'h4433_2211) begin
      bad++; $display("FAIL commit_write: commit=%02h reg1=%h expected 02/44332211", commit, rw_regs[63:32]);
    end
    cyc();
    total++;
    if (commit !== '0) begin bad++; $display("FAIL commit_width: commit=%02h expected 00", commit); end
    gap(); send_stop();
  endtask

  task automatic test_aborted_write();
    int c0;
    c0 = commit_seen;
    send_start(1'b0); send_byte(8'h08); send_byte(8'hAA); send_byte(8'hBB); send_stop();
    send_start(1'b0); send_byte(8'h08); send_byte(8'hCC); send_byte(8'hDD); send_byte(8'hEE);
    rx_data = 8'hFF; data_vld = 1'b1; stop = 1'b1; cyc(); data_vld = 1'b0; stop = 1'b0; gap();
    send_start(1'b0); send_byte(8'h08); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    rx_data = 8'h44; data_vld = 1'b1; r_w = 1'b0; start = 1'b1; cyc();
    data_vld = 1'b0; start = 1'b0; gap();
    send_stop();
    total++;
    if (rw_regs[95:64] !== R2) begin bad++; $display("FAIL abort_reg2: reg2=%h expected %h", rw_regs[95:64], R2); end
    total++;
    if (commit_seen != c0) begin bad++; $display("FAIL abort_commit: %0d commit cycles expected 0", commit_seen - c0); end
  endtask

  task automatic test_ro_coherent();
    send_start(1'b0); send_byte(8'h40);
    send_start(1'b1);
    exp_q.push_back(8'h78); exp_q.push_back(8'h56); exp_q.push_back(8'h34); exp_q.push_back(8'h12);
    send_byte(8'h00);
    ro_regs[31:0] = 32'h9ABC_DEF0;
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_stop();
    send_start(1'b0); send_byte(8'h40); send_start(1'b1);
    exp_q.push_back(8'hF0); exp_q.push_back(8'hDE); exp_q.push_back(8'hBC); exp_q.push_back(8'h9A);
    for (int i = 0; i < 4; i++) send_byte(8'h00);
    send_stop();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL ro_left: %0d bytes not read, expected 0", exp_q.size()); end
  endtask

  task automatic test_pulse();
    logic [31:0] seen [0:6];
    logic [31:0] want [0:6];
    want = '{32'h1, 32'h1, 32'h1, 32'h0200_0000, 32'h0200_0000, 32'h0200_0000, 32'h0};
    send_start(1'b0); send_byte(8'h1C);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    rx_data = 8'h00; data_vld = 1'b1; cyc(); data_vld = 1'b0;
    seen[0] = rw_regs[255:224];
    r_w = 1'b0; start = 1'b1; cyc(); start = 1'b0;
    seen[1] = rw_regs[255:224];
    rx_data = 8'h1F; data_vld = 1'b1; cyc();
    seen[2] = rw_regs[255:224];
    rx_data = 8'h02; cyc(); data_vld = 1'b0;
    seen[3] = rw_regs[255:224];
    cyc(); seen[4] = rw_regs[255:224];
    cyc(); seen[5] = rw_regs[255:224];
    cyc(); seen[6] = rw_regs[255:224];
    for (int i = 0; i < 7; i++) begin
      total++;
      if (seen[i] !== want[i]) begin bad++; $display("FAIL pulse_c%0d: reg7=%h expected %h", i, seen[i], want[i]); end
    end
    gap(); send_stop();
    send_start(1'b0); send_byte(8'h1C);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    repeat (3) cyc();
    total++;
    if (rw_regs[255:224] !== 32'h0) begin bad++; $display("FAIL pulse_expire: reg7=%h expected 0", rw_regs[255:224]); end
    send_stop();
  endtask

  task automatic test_wrap();
    send_start(1'b0); send_byte(8'hFE);
    send_start(1'b1);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(R0[7:0]);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_stop();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL wrap_left: %0d bytes not read, expected 0", exp_q.size()); end
  endtask

  task automatic test_unmapped();
    int a0, c0;
    logic [N_RW*REG_W-1:0] save;
    a0 = aerr_seen; c0 = commit_seen; save = rw_regs;
    send_start(1'b0); send_byte(8'h30); send_byte(8'h5A); send_stop();
    total++;
    if (aerr_seen != a0 + 1) begin bad++; $display("FAIL aerr_unmapped: %0d strobes expected 1", aerr_seen - a0); end
    send_start(1'b0); send_byte(8'h43); send_byte(8'h77); send_stop();
    total++;
    if (aerr_seen != a0 + 2) begin bad++; $display("FAIL aerr_ro: %0d strobes expected 2", aerr_seen - a0); end
    total++;
    if (rw_regs !== save || commit_seen != c0) begin
      bad++; $display("FAIL unmapped_side_effect: rw=%h commits=%0d expected %h/0", rw_regs, commit_seen - c0, save);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; data_vld = 1'b0; r_w = 1'b0; rx_data = 8'h00;
    ro_regs = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1234_5678};
    repeat (3) cyc();
    test_reset();
    test_atomic_write();
    test_aborted_write();
    test_ro_coherent();
    test_pulse();
    test_wrap();
    test_unmapped();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
